// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - decode-facing output register with a single-entry skid slot
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_flush,
   input  logic                  i_push_valid,
   input  logic [DATA_WIDTH-1:0] i_push_instr,
   input  logic [DATA_WIDTH-1:0] i_push_pc,
   input  logic                  i_out_ready,
   output logic                  o_out_valid,
   output logic [DATA_WIDTH-1:0] o_out_instr,
   output logic [DATA_WIDTH-1:0] o_out_pc,
   output logic [DATA_WIDTH-1:0] o_out_pc_plus4,
   output logic                  o_skid_empty_next
);

   localparam logic [DATA_WIDTH-1:0] W_NOP = DATA_WIDTH'(NOP_INSTR);

   logic                  r_out_valid;
   logic [DATA_WIDTH-1:0] r_out_instr;
   logic [DATA_WIDTH-1:0] r_out_pc;
   logic [DATA_WIDTH-1:0] r_out_pc_plus4;
   logic                  r_skid_valid;
   logic [DATA_WIDTH-1:0] r_skid_instr;
   logic [DATA_WIDTH-1:0] r_skid_pc;

   logic                  w_consume;
   logic                  w_out_free;

   assign w_consume  = r_out_valid & i_out_ready;
   assign w_out_free = ~r_out_valid | w_consume;

   // Skid occupancy after the coming edge; the fetch FSM uses it to decide whether to keep requesting
   always_comb begin
      o_skid_empty_next = 1'b1;
      if (!i_flush) begin
         if (w_out_free) begin
            o_skid_empty_next = ~(r_skid_valid & i_push_valid);
         end else begin
            o_skid_empty_next = ~(r_skid_valid | i_push_valid);
         end
      end
   end

   // Output register and skid slot: the skid entry is older, so it always drains ahead of new data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid    <= 1'b0;
         r_out_instr    <= W_NOP;
         r_out_pc       <= '0;
         r_out_pc_plus4 <= '0;
         r_skid_valid   <= 1'b0;
         r_skid_instr   <= W_NOP;
         r_skid_pc      <= '0;
      end else if (i_flush) begin
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (w_out_free) begin
         if (r_skid_valid) begin
            r_out_valid    <= 1'b1;
            r_out_instr    <= r_skid_instr;
            r_out_pc       <= r_skid_pc;
            r_out_pc_plus4 <= r_skid_pc + DATA_WIDTH'(4);
            r_skid_valid   <= i_push_valid;
            if (i_push_valid) begin
               r_skid_instr <= i_push_instr;
               r_skid_pc    <= i_push_pc;
            end
         end else if (i_push_valid) begin
            r_out_valid    <= 1'b1;
            r_out_instr    <= i_push_instr;
            r_out_pc       <= i_push_pc;
            r_out_pc_plus4 <= i_push_pc + DATA_WIDTH'(4);
         end else begin
            r_out_valid <= 1'b0;
         end
      end else if (i_push_valid) begin
         r_skid_valid <= 1'b1;
         r_skid_instr <= i_push_instr;
         r_skid_pc    <= i_push_pc;
      end
   end

   assign o_out_valid    = r_out_valid;
   assign o_out_instr    = r_out_valid ? r_out_instr : W_NOP;
   assign o_out_pc       = r_out_pc;
   assign o_out_pc_plus4 = r_out_pc_plus4;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC register, imem request FSM and decode output buffer
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                      DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0]   RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  redirect,
   input  logic [DATA_WIDTH-1:0] redirect_pc,
   output logic                  imem_req,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic                  imem_ack,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [DATA_WIDTH-1:0] pc,
   output logic [DATA_WIDTH-1:0] pc_plus4,
   output logic                  instr_valid
);

   fetch_state_t          r_state;
   fetch_state_t          w_next_state;
   logic [DATA_WIDTH-1:0] r_fetch_pc;
   logic [DATA_WIDTH-1:0] r_drop_addr;

   logic [DATA_WIDTH-1:0] w_redirect_pc;
   logic                  w_fetch_ack;
   logic                  w_push;
   logic                  w_out_ready;
   logic                  w_skid_empty_next;

   // Low two bits of a redirect target are dropped so every request stays word aligned
   assign w_redirect_pc = redirect_pc & ~DATA_WIDTH'(3);
   assign w_fetch_ack   = (r_state == REQ) & imem_ack;
   assign w_push        = w_fetch_ack & ~redirect;
   assign w_out_ready   = ~stall;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; redirect outranks both stall and ack
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (redirect || w_skid_empty_next) begin
               w_next_state = REQ;
            end
         end
         REQ: begin
            if (redirect) begin
               w_next_state = imem_ack ? REQ : DROP;
            end else if (imem_ack) begin
               w_next_state = w_skid_empty_next ? REQ : IDLE;
            end
         end
         DROP: begin
            if (imem_ack) begin
               w_next_state = REQ;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Output logic; a DROP request keeps presenting the stale address until memory acknowledges it
   always_comb begin
      imem_req  = (r_state != IDLE);
      imem_addr = (r_state == DROP) ? r_drop_addr : r_fetch_pc;
   end

   // Fetch PC advances on each accepted fetch and jumps on redirect; wraps modulo 2^DATA_WIDTH
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_pc <= RESET_PC;
      end else if (redirect) begin
         r_fetch_pc <= w_redirect_pc;
      end else if (w_fetch_ack) begin
         r_fetch_pc <= r_fetch_pc + DATA_WIDTH'(4);
      end
   end

   // Capture the in-flight address when a redirect orphans an unacknowledged request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_drop_addr <= '0;
      end else if ((r_state == REQ) && redirect && !imem_ack) begin
         r_drop_addr <= r_fetch_pc;
      end
   end

   fetch_buffer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_buffer (
      .clk               (clk),
      .rst               (rst),
      .i_flush           (redirect),
      .i_push_valid      (w_push),
      .i_push_instr      (imem_rdata),
      .i_push_pc         (r_fetch_pc),
      .i_out_ready       (w_out_ready),
      .o_out_valid       (instr_valid),
      .o_out_instr       (instr),
      .o_out_pc          (pc),
      .o_out_pc_plus4    (pc_plus4),
      .o_skid_empty_next (w_skid_empty_next)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] OFS = 32'h1000_0000;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        instr_valid;

   int tests_run;
   int tests_failed;

   fetch_unit #(
      .DATA_WIDTH (32),
      .RESET_PC   (32'h0000_0000)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .instr_valid (instr_valid)
   );

   // Instruction memory image: each word is its own address plus a fixed offset
   assign imem_rdata = imem_addr + OFS;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply_reset(input logic ack_val);
      rst         = 1'b1;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      imem_ack    = ack_val;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; imem_ack = 1'b1;
      #3;
      rst = 1'b1;
      #1;
      tests_run++;
      if ({imem_req, instr_valid} !== 2'b00) begin
         tests_failed++;
         $display("FAIL reset_ctrl: req/valid got %b expected 00", {imem_req, instr_valid});
      end
      tests_run++;
      if (instr !== NOP) begin
         tests_failed++;
         $display("FAIL reset_instr: got %h expected %h", instr, NOP);
      end
      tests_run++;
      if ({pc, pc_plus4} !== 64'h0) begin
         tests_failed++;
         $display("FAIL reset_pc: pc %h pc_plus4 %h expected 0 0", pc, pc_plus4);
      end
      repeat (2) @(negedge clk);
      tests_run++;
      if ({imem_req, instr_valid} !== 2'b00) begin
         tests_failed++;
         $display("FAIL reset_hold: req/valid got %b expected 00", {imem_req, instr_valid});
      end
   endtask

   task automatic test_streaming();
      logic [31:0] exp_pc;
      apply_reset(1'b1);
      @(negedge clk);
      tests_run++;
      if ({imem_req, instr_valid, imem_addr} !== {1'b1, 1'b0, 32'h0}) begin
         tests_failed++;
         $display("FAIL stream_first_req: req %b valid %b addr %h expected 1 0 00000000",
                  imem_req, instr_valid, imem_addr);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         exp_pc = 32'(i * 4);
         tests_run++;
         if ({instr_valid, pc, pc_plus4, instr} !== {1'b1, exp_pc, exp_pc + 32'd4, exp_pc + OFS}) begin
            tests_failed++;
            $display("FAIL stream_%0d: valid %b pc %h pc4 %h instr %h expected 1 %h %h %h",
                     i, instr_valid, pc, pc_plus4, instr, exp_pc, exp_pc + 32'd4, exp_pc + OFS);
         end
      end
   endtask

   task automatic test_stall();
      apply_reset(1'b1);
      repeat (4) @(negedge clk);
      tests_run++;
      if ({instr_valid, pc} !== {1'b1, 32'h8}) begin
         tests_failed++;
         $display("FAIL stall_setup: valid %b pc %h expected 1 00000008", instr_valid, pc);
      end
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests_run++;
         if ({instr_valid, pc, instr, imem_req} !== {1'b1, 32'h8, 32'h1000_0008, 1'b0}) begin
            tests_failed++;
            $display("FAIL stall_hold_%0d: valid %b pc %h instr %h req %b expected 1 00000008 10000008 0",
                     i, instr_valid, pc, instr, imem_req);
         end
      end
      stall = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({instr_valid, pc, instr} !== {1'b1, 32'hC, 32'h1000_000C}) begin
         tests_failed++;
         $display("FAIL stall_skid_out: valid %b pc %h instr %h expected 1 0000000c 1000000c",
                  instr_valid, pc, instr);
      end
      @(negedge clk);
      tests_run++;
      if ({instr_valid, pc, pc_plus4} !== {1'b1, 32'h10, 32'h14}) begin
         tests_failed++;
         $display("FAIL stall_resume: valid %b pc %h pc4 %h expected 1 00000010 00000014",
                  instr_valid, pc, pc_plus4);
      end
   endtask

   task automatic test_slow_mem();
      apply_reset(1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         tests_run++;
         if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h0, 1'b0}) begin
            tests_failed++;
            $display("FAIL slow_wait_%0d: req %b addr %h valid %b expected 1 00000000 0",
                     i, imem_req, imem_addr, instr_valid);
         end
      end
      imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      tests_run++;
      if ({instr_valid, pc, instr, imem_addr} !== {1'b1, 32'h0, 32'h1000_0000, 32'h4}) begin
         tests_failed++;
         $display("FAIL slow_deliver: valid %b pc %h instr %h addr %h expected 1 00000000 10000000 00000004",
                  instr_valid, pc, instr, imem_addr);
      end
      @(negedge clk);
      tests_run++;
      if ({instr_valid, instr} !== {1'b0, NOP}) begin
         tests_failed++;
         $display("FAIL slow_once: valid %b instr %h expected 0 %h", instr_valid, instr, NOP);
      end
   endtask

   task automatic test_redirect_drop();
      apply_reset(1'b1);
      repeat (9) @(negedge clk);
      tests_run++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h20}) begin
         tests_failed++;
         $display("FAIL drop_setup: req %b addr %h expected 1 00000020", imem_req, imem_addr);
      end
      imem_ack    = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0100;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         redirect = 1'b0;
         tests_run++;
         if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h20, 1'b0}) begin
            tests_failed++;
            $display("FAIL drop_hold_%0d: req %b addr %h valid %b expected 1 00000020 0",
                     i, imem_req, imem_addr, instr_valid);
         end
      end
      imem_ack = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h100, 1'b0}) begin
         tests_failed++;
         $display("FAIL drop_discard: req %b addr %h valid %b expected 1 00000100 0",
                  imem_req, imem_addr, instr_valid);
      end
      @(negedge clk);
      tests_run++;
      if ({instr_valid, pc, instr} !== {1'b1, 32'h100, 32'h1000_0100}) begin
         tests_failed++;
         $display("FAIL drop_target: valid %b pc %h instr %h expected 1 00000100 10000100",
                  instr_valid, pc, instr);
      end
   endtask

   task automatic test_redirect_stall();
      apply_reset(1'b1);
      repeat (4) @(negedge clk);
      stall = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({instr_valid, pc, imem_req} !== {1'b1, 32'h8, 1'b0}) begin
         tests_failed++;
         $display("FAIL rs_setup: valid %b pc %h req %b expected 1 00000008 0", instr_valid, pc, imem_req);
      end
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0203;
      @(negedge clk);
      redirect = 1'b0;
      stall    = 1'b0;
      tests_run++;
      if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h200}) begin
         tests_failed++;
         $display("FAIL rs_flush: valid %b req %b addr %h expected 0 1 00000200",
                  instr_valid, imem_req, imem_addr);
      end
      @(negedge clk);
      tests_run++;
      if ({instr_valid, pc, pc_plus4, instr} !== {1'b1, 32'h200, 32'h204, 32'h1000_0200}) begin
         tests_failed++;
         $display("FAIL rs_target: valid %b pc %h pc4 %h instr %h expected 1 00000200 00000204 10000200",
                  instr_valid, pc, pc_plus4, instr);
      end
      @(negedge clk);
      tests_run++;
      if ({instr_valid, pc} !== {1'b1, 32'h204}) begin
         tests_failed++;
         $display("FAIL rs_no_stale: valid %b pc %h expected 1 00000204", instr_valid, pc);
      end
   endtask

   task automatic test_wrap_reset();
      apply_reset(1'b1);
      @(negedge clk);
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      @(negedge clk);
      redirect = 1'b0;
      tests_run++;
      if ({instr_valid, imem_addr} !== {1'b0, 32'hFFFF_FFFC}) begin
         tests_failed++;
         $display("FAIL wrap_redirect: valid %b addr %h expected 0 fffffffc", instr_valid, imem_addr);
      end
      @(negedge clk);
      tests_run++;
      if ({instr_valid, pc, pc_plus4, imem_addr} !== {1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0}) begin
         tests_failed++;
         $display("FAIL wrap_pc: valid %b pc %h pc4 %h addr %h expected 1 fffffffc 00000000 00000000",
                  instr_valid, pc, pc_plus4, imem_addr);
      end
      stall    = 1'b1;
      imem_ack = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({instr_valid, pc, imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0}) begin
         tests_failed++;
         $display("FAIL wrap_pending: valid %b pc %h req %b addr %h expected 1 fffffffc 1 00000000",
                  instr_valid, pc, imem_req, imem_addr);
      end
      #2;
      rst = 1'b1;
      #1;
      tests_run++;
      if ({instr_valid, imem_req, instr, pc} !== {1'b0, 1'b0, NOP, 32'h0}) begin
         tests_failed++;
         $display("FAIL async_reset: valid %b req %b instr %h pc %h expected 0 0 %h 00000000",
                  instr_valid, imem_req, instr, pc, NOP);
      end
      @(negedge clk);
      rst      = 1'b0;
      stall    = 1'b0;
      imem_ack = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h0, 1'b0}) begin
         tests_failed++;
         $display("FAIL wrap_restart: req %b addr %h valid %b expected 1 00000000 0",
                  imem_req, imem_addr, instr_valid);
      end
      @(negedge clk);
      tests_run++;
      if ({instr_valid, pc, instr} !== {1'b1, 32'h0, 32'h1000_0000}) begin
         tests_failed++;
         $display("FAIL wrap_after_reset: valid %b pc %h instr %h expected 1 00000000 10000000",
                  instr_valid, pc, instr);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_streaming();
      test_stall();
      test_slow_mem();
      test_redirect_drop();
      test_redirect_stall();
      test_wrap_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of the PC, address and instruction paths.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-003 Port list (name, direction, width, meaning):
  clk  in  1  sole clock; all state updates on rising edge
  rst  in  1  asynchronous, active-high reset
  stall  in  1  decode cannot accept; the output holds
  redirect  in  1  control-flow change (branch, jal or jalr taken)
  redirect_pc  in  DATA_WIDTH  new fetch address; valid with redirect
  imem_req  out  1  instruction-memory request
  imem_addr  out  DATA_WIDTH  request address; word aligned
  imem_ack  in  1  request accepted; imem_rdata valid in the same cycle
  imem_rdata  in  DATA_WIDTH  fetched instruction word
  instr  out  DATA_WIDTH  instruction presented to decode
  pc  out  DATA_WIDTH  address of instr
  pc_plus4  out  DATA_WIDTH  pc + 4, for jal/jalr link
  instr_valid  out  1  instr/pc/pc_plus4 are meaningful

Function
REQ-004 imem handshake: once imem_req rises, imem_req and imem_addr SHALL stay stable until the cycle in which imem_ack is high; only one request SHALL be outstanding.
REQ-005 The FSM SHALL have three states. IDLE: no request. REQ: request to fetch_pc. DROP: request to a stale address whose data is discarded.
REQ-006 IDLE -> REQ when the skid buffer is empty; otherwise stay in IDLE.
REQ-007 REQ with ack: fetch_pc += 4. The next state SHALL be REQ if the skid buffer is empty after this edge, else IDLE.
REQ-008 REQ without ack: stay in REQ.
REQ-009 DROP with ack: discard imem_rdata and go to REQ; fetch_pc already holds redirect_pc.
REQ-010 DROP without ack: stay in DROP.
REQ-011 Output register: accepted data SHALL load the output register (instr, pc, pc_plus4, instr_valid=1) if it is empty or consumed this cycle; otherwise it SHALL load the single-entry skid buffer.
REQ-012 Consumption: the output is consumed when instr_valid=1 and stall=0. On consumption, a valid skid entry SHALL move to the output register in the same edge, ahead of any new data.
REQ-013 Hold: while stall=1, instr/pc/pc_plus4/instr_valid SHALL hold unchanged.
REQ-014 Latency: with imem_ack tied high and stall=0, one instruction per cycle after the first. The first instr_valid SHALL rise 1 cycle after the first ack edge.
REQ-015 Redirect priority: redirect SHALL take priority over stall and over ack.
REQ-016 Redirect effects in the same edge: fetch_pc <= redirect_pc; instr_valid and skid valid cleared; ack data of that cycle discarded.
REQ-017 Redirect state transitions: from REQ without ack, next state = DROP. From REQ with ack, from IDLE, or from DROP with ack, next state = REQ.
REQ-018 A redirect during DROP without ack SHALL update fetch_pc and remain in DROP.
REQ-019 PC arithmetic SHALL be modulo 2^DATA_WIDTH: 32'hFFFF_FFFC + 4 wraps to 0.
REQ-020 redirect_pc[1:0] SHALL be ignored (forced to 00).
REQ-021 When instr_valid=0, instr SHALL read NOP (32'h0000_0013).

Reset
REQ-022 While rst=1, independent of clk: fetch_pc=RESET_PC, state=IDLE, imem_req=0, instr_valid=0, skid empty, instr=NOP, pc=0, pc_plus4=0.
REQ-023 A reset asserted during an outstanding request SHALL abandon that request.
REQ-024 The first request after reset SHALL issue on the first edge after rst falls.

Structure
REQ-025 Package fetch_pkg SHALL hold the state enum (IDLE/REQ/DROP), the NOP constant and the default RESET_PC.
REQ-026 The output register plus skid entry SHALL be one sub-module, fetch_buffer (two entries, valid/ready style).
REQ-027 All remaining logic (FSM, PC register) SHALL stay in fetch_unit.

Verification
REQ-028 Streaming: reset, ack tied 1, stall 0 -> instr_valid with pc 0,4,8,12 on consecutive cycles; pc_plus4 4,8,12,16.
REQ-029 Stall: stall=1 for 3 cycles while pc=8 is valid -> output holds pc=8; skid holds pc=12; imem_req drops; after release pc 12 then 16 arrive with no gap and no loss.
REQ-030 Slow memory: ack delayed 3 cycles -> imem_addr stays 0 for 4 cycles; pc=0 delivered once.
REQ-031 Redirect to 32'h100 while a request to 0x20 is unacked -> DROP; the 0x20 data is never valid; the next valid pc is 0x100.
REQ-032 Redirect and stall together with the skid full -> the output and skid are flushed; the next valid pc equals redirect_pc.
REQ-033 Wrap and reset: redirect to 32'hFFFF_FFFC then reset mid-request -> pc FFFF_FFFC, then 0. An async reset between edges clears instr_valid immediately.
